// File: rtl/display_scheduler.sv
// Round-robin scheduler that time-multiplexes debug values onto one seven-segment display.
// Define DISPLAY_SCHED_TAG_EN to overwrite the top nibble of display_o with the shown index.
module display_scheduler #(
   parameter int unsigned NUM_SRC      = 4,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned DWELL_CYCLES = 2**26
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic [DATA_WIDTH-1:0]      src_data_i [NUM_SRC],
   input  logic [NUM_SRC-1:0]         src_valid_i,
   input  logic                       next_i,
   input  logic                       pin_en_i,
   input  logic [$clog2(NUM_SRC)-1:0] pin_sel_i,
   output logic [DATA_WIDTH-1:0]      display_o,
   output logic [$clog2(NUM_SRC)-1:0] cur_sel_o,
   output logic                       switch_o,
   output logic                       idle_o
);

   localparam int unsigned SelW = $clog2(NUM_SRC);
   localparam int unsigned CntW = $clog2(DWELL_CYCLES);

   typedef enum logic [1:0] {StIdle, StShow, StPin} state_e;

   state_e                state_q, state_d;
   logic [SelW-1:0]       sel_q, sel_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] display_q, display_d;
   logic                  switch_q, switch_d;
   logic                  next_q;

   logic            next_edge;
   logic            any_valid;
   logic            advance;
   logic [SelW-1:0] tgt;
   logic [SelW-1:0] idx;
   logic            found;

   assign next_edge = next_i & ~next_q;
   assign any_valid = |src_valid_i;
   assign advance   = (cnt_q == CntW'(DWELL_CYCLES - 1)) | next_edge | ~src_valid_i[sel_q];

   // Cyclic search starting one past the current index; ends on itself if it is the sole valid.
   always_comb begin
      tgt   = sel_q;
      found = 1'b0;
      idx   = '0;
      for (int unsigned i = 1; i <= NUM_SRC; i++) begin
         idx = SelW'((32'(sel_q) + i) % NUM_SRC);
         if (!found && src_valid_i[idx]) begin
            tgt   = idx;
            found = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            if (pin_en_i) begin
               state_d = StPin;
               sel_d   = pin_sel_i;
            end else if (any_valid) begin
               state_d = StShow;
               sel_d   = tgt;
            end
         end
         StShow: begin
            if (pin_en_i) begin
               state_d = StPin;
               sel_d   = pin_sel_i;
               cnt_d   = '0;
            end else if (!any_valid) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else if (advance) begin
               sel_d = tgt;
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StPin: begin
            cnt_d = '0;
            if (pin_en_i) begin
               sel_d = pin_sel_i;
            end else begin
               state_d = any_valid ? StShow : StIdle;
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
   end

   assign switch_d = (sel_d != sel_q);

   always_comb begin
      display_d = display_q;
      if (state_q != StIdle) begin
         display_d = src_data_i[sel_q];
`ifdef DISPLAY_SCHED_TAG_EN
         display_d[DATA_WIDTH-1 -: 4] = 4'(sel_q);
`endif
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= StIdle;
         sel_q     <= SelW'(NUM_SRC - 1);
         cnt_q     <= '0;
         display_q <= '0;
         switch_q  <= 1'b0;
         next_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         cnt_q     <= cnt_d;
         display_q <= display_d;
         switch_q  <= switch_d;
         next_q    <= next_i;
      end
   end

   assign display_o = display_q;
   assign cur_sel_o = sel_q;
   assign switch_o  = switch_q;
   assign idle_o    = (state_q == StIdle);

endmodule

// File: tb/tb_display_scheduler.sv
// Directed self-checking bench for display_scheduler with a short dwell of 8 cycles.
module tb_display_scheduler;

   logic        clk;
   logic        rst_ni;
   logic [31:0] src_data [4];
   logic [3:0]  src_valid;
   logic        next_i;
   logic        pin_en;
   logic [1:0]  pin_sel;
   logic [31:0] display;
   logic [1:0]  cur_sel;
   logic        switch_p;
   logic        idle;

   int checks   = 0;
   int failures = 0;

   display_scheduler #(
      .NUM_SRC      (4),
      .DATA_WIDTH   (32),
      .DWELL_CYCLES (8)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_ni),
      .src_data_i  (src_data),
      .src_valid_i (src_valid),
      .next_i      (next_i),
      .pin_en_i    (pin_en),
      .pin_sel_i   (pin_sel),
      .display_o   (display),
      .cur_sel_o   (cur_sel),
      .switch_o    (switch_p),
      .idle_o      (idle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_switch(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!switch_p && n < 50);
   endtask

   function automatic logic [31:0] exp_disp(input int sel, input logic [31:0] d);
      logic [31:0] r;
      r = d;
`ifdef DISPLAY_SCHED_TAG_EN
      r[31:28] = 4'(sel);
`endif
      return r;
   endfunction

   initial begin
      int n;
      int pulses;
      int bad;
      int order [4];
      order = '{1, 2, 3, 0};
      rst_ni    = 1'b1;
      src_data  = '{32'h0, 32'h0, 32'h0, 32'h0};
      src_valid = 4'b0000;
      next_i    = 1'b0;
      pin_en    = 1'b0;
      pin_sel   = 2'd0;
      #2 rst_ni = 1'b0;
      #2;
      check("rst_idle", 32'(idle), 32'd1);
      check("rst_disp", display, 32'h0);
      check("rst_sel", 32'(cur_sel), 32'd3);
      check("rst_switch", 32'(switch_p), 32'd0);
      #8 rst_ni = 1'b1;

      // No valid sources: stays idle and silent.
      pulses = 0;
      bad    = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         pulses += int'(switch_p);
         if (idle !== 1'b1) bad++;
      end
      check("idle_pulses", 32'(pulses), 32'd0);
      check("idle_flag", 32'(bad), 32'd0);
      check("idle_disp", display, 32'h0);

      // Full rotation with all four sources valid.
      src_data  = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
      src_valid = 4'b1111;
      tick();
      check("first_sel", 32'(cur_sel), 32'd0);
      check("first_switch", 32'(switch_p), 32'd1);
      check("first_idle", 32'(idle), 32'd0);
      tick();
      check("first_disp", display, exp_disp(0, 32'h1111_1111));
      for (int k = 0; k < 4; k++) begin
         wait_switch(n);
         check("rot_period", 32'(n), 32'd7);
         check("rot_sel", 32'(cur_sel), 32'(order[k]));
         tick();
         check("rot_disp", display, exp_disp(order[k], src_data[order[k]]));
      end

      // Sparse valid set, then current source dropped.
      src_valid = 4'b0101;
      wait_switch(n);
      check("sparse_period", 32'(n), 32'd7);
      check("sparse_sel", 32'(cur_sel), 32'd2);
      src_valid = 4'b0001;
      tick();
      check("drop_sel", 32'(cur_sel), 32'd0);
      check("drop_switch", 32'(switch_p), 32'd1);
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         pulses += int'(switch_p);
      end
      check("sole_pulses", 32'(pulses), 32'd0);
      check("sole_sel", 32'(cur_sel), 32'd0);

      // Manual advance: a held level steps once; coincident expiry steps once.
      src_valid = 4'b1111;
      wait_switch(n);
      check("resync_sel", 32'(cur_sel), 32'd1);
      tick();
      tick();
      tick();
      next_i = 1'b1;
      tick();
      check("next_sel", 32'(cur_sel), 32'd2);
      check("next_switch", 32'(switch_p), 32'd1);
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         pulses += int'(switch_p);
      end
      check("next_held", 32'(pulses), 32'd0);
      next_i = 1'b0;
      tick();
      check("pre_coinc_switch", 32'(switch_p), 32'd0);
      next_i = 1'b1;
      tick();
      check("coinc_sel", 32'(cur_sel), 32'd3);
      check("coinc_switch", 32'(switch_p), 32'd1);
      tick();
      check("coinc_single_sel", 32'(cur_sel), 32'd3);
      check("coinc_single_sw", 32'(switch_p), 32'd0);
      next_i = 1'b0;

      // Pinning ignores valid flags and button edges.
      pin_en  = 1'b1;
      pin_sel = 2'd2;
      tick();
      check("pin_sel", 32'(cur_sel), 32'd2);
      check("pin_switch", 32'(switch_p), 32'd1);
      pulses = 0;
      bad    = 0;
      for (int i = 0; i < 50; i++) begin
         src_valid = 4'(i);
         next_i    = i[0];
         tick();
         if (cur_sel !== 2'd2) bad++;
         pulses += int'(switch_p);
      end
      check("pin_hold", 32'(bad), 32'd0);
      check("pin_pulses", 32'(pulses), 32'd0);
      check("pin_disp", display, exp_disp(2, 32'h3333_3333));
      next_i    = 1'b0;
      src_valid = 4'b1111;
      tick();
      pin_en = 1'b0;
      tick();
      check("unpin_sel", 32'(cur_sel), 32'd2);
      check("unpin_idle", 32'(idle), 32'd0);
      check("unpin_switch", 32'(switch_p), 32'd0);
      wait_switch(n);
      check("unpin_period", 32'(n), 32'd8);
      check("unpin_next", 32'(cur_sel), 32'd3);
      tick();
      check("unpin_disp", display, exp_disp(3, 32'h4444_4444));
      src_data[3] = 32'h5555_AAAA;
      tick();
      check("live_disp", display, exp_disp(3, 32'h5555_AAAA));

      // Page tag (when enabled) and asynchronous reset mid-dwell.
      src_data[1] = 32'hABCD_1234;
      wait_switch(n);
      check("tag_pre_period", 32'(n), 32'd6);
      wait_switch(n);
      check("tag_sel", 32'(cur_sel), 32'd1);
      tick();
      check("tag_disp", display, exp_disp(1, 32'hABCD_1234));
      tick();
      tick();
      #1 rst_ni = 1'b0;
      #1;
      check("arst_sel", 32'(cur_sel), 32'd3);
      check("arst_idle", 32'(idle), 32'd1);
      check("arst_switch", 32'(switch_p), 32'd0);
      check("arst_disp", display, 32'h0);
      #1 rst_ni = 1'b1;
      #1;
      check("release_sel", 32'(cur_sel), 32'd3);
      tick();
      check("restart_sel", 32'(cur_sel), 32'd0);
      check("restart_switch", 32'(switch_p), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
